// File: rtl/adder_trigger_guard.sv
// Registered a+b+cin adder with valid/ready handshake and a repeated-vector trigger monitor.
// Optional build macro ADDER_GUARD_QUARANTINE_EN blocks new vectors while the alarm is raised.
module adder_trigger_guard #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned REPEAT_LIMIT = 6,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             alarm,
  input  logic             alarm_clr,
  output logic [CNT_W-1:0] repeat_cnt
);

  localparam int unsigned    KeyW     = 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntLimit = CNT_W'(REPEAT_LIMIT);

`ifdef ADDER_GUARD_QUARANTINE_EN
  localparam bit Quarantine = 1'b1;
`else
  localparam bit Quarantine = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StTrack, StAlarm} state_e;

  state_e            state_q, state_d;
  logic [KeyW-1:0]   key_q, key_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              alarm_q, alarm_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH:0]    res_q, res_d;

  logic              accept;
  logic [KeyW-1:0]   key;
  logic [WIDTH:0]    sum_full;

  assign in_ready = (!out_valid_q || out_ready) && !(Quarantine && alarm_q);
  assign accept   = in_valid && in_ready;
  assign key      = {a, b, cin};
  assign sum_full = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);

  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (accept) begin
      out_valid_d = 1'b1;
      res_d       = sum_full;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    if (alarm_clr) begin
      // The clear ends the old run; a simultaneous accept seeds a fresh one.
      alarm_d = 1'b0;
      if (accept) begin
        state_d = StTrack;
        key_d   = key;
        cnt_d   = CntOne;
      end else begin
        state_d = StIdle;
        key_d   = '0;
        cnt_d   = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d = StTrack;
            key_d   = key;
            cnt_d   = CntOne;
          end
        end
        StTrack: begin
          if (accept) begin
            if (key == key_q) begin
              cnt_d = cnt_q + CntOne;
            end else begin
              key_d = key;
              cnt_d = CntOne;
            end
            if (cnt_d == CntLimit) begin
              state_d = StAlarm;
              alarm_d = 1'b1;
            end
          end
        end
        StAlarm: begin
          alarm_d = 1'b1;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      key_q       <= '0;
      cnt_q       <= '0;
      alarm_q     <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      alarm_q     <= alarm_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign sum        = res_q[WIDTH-1:0];
  assign cout       = res_q[WIDTH];
  assign alarm      = alarm_q;
  assign repeat_cnt = cnt_q;

endmodule
